instruction_encoder: RTL and testbench

Inverse of the core's instruction decoder. Accepts decoded RV32I operation records (operation_t plus register indices and immediate) over a valid/ready handshake, packs them into 32-bit machine words, and streams them with incrementing word addresses to the instruction-memory write port. Used as the on-chip program loader and as the stimulus generator for decoder verification. One registered encode stage feeds a small output FIFO. Invalid or unencodable records raise a sticky error.

---
 rtl/instruction_encoder_pkg.sv | 89 ++++++++
 rtl/instruction_encoder_if.sv | 25 ++
 rtl/instruction_encoder_sync_fifo.sv | 45 ++++
 rtl/instruction_encoder.sv | 100 ++++++++++
 tb/tb_instruction_encoder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: operation set, opcode/funct3
// constants, instruction formats and the per-operation encoding lookup.
package instruction_encoder_pkg;

  typedef enum logic [5:0] {
    lui, auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu,
    lb, lh, lw, lbu, lhu, sb, sh, sw,
    addi, slti, sltiu, xori, ori, andi, slli, srli, srai,
    add, sub, sll, slt, sltu, xor_, srl, sra, or_, and_,
    fence, system, invalid
  } operation_t;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SHIFT, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } format_t;

  typedef struct packed {
    format_t    fmt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } op_info_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  // fence/system and anything unknown fall through to FMT_NONE (unencodable).
  function automatic op_info_t op_info(operation_t op);
    op_info_t r;
    r = '{FMT_NONE, 7'd0, 3'd0, 7'd0};
    case (op)
      lui:   r = '{FMT_U, OPC_LUI, 3'd0, 7'd0};
      auipc: r = '{FMT_U, OPC_AUIPC, 3'd0, 7'd0};
      jal:   r = '{FMT_J, OPC_JAL, 3'd0, 7'd0};
      jalr:  r = '{FMT_I, OPC_JALR, 3'd0, 7'd0};
      beq:   r = '{FMT_B, OPC_BRANCH, 3'd0, 7'd0};
      bne:   r = '{FMT_B, OPC_BRANCH, 3'd1, 7'd0};
      blt:   r = '{FMT_B, OPC_BRANCH, 3'd4, 7'd0};
      bge:   r = '{FMT_B, OPC_BRANCH, 3'd5, 7'd0};
      bltu:  r = '{FMT_B, OPC_BRANCH, 3'd6, 7'd0};
      bgeu:  r = '{FMT_B, OPC_BRANCH, 3'd7, 7'd0};
      lb:    r = '{FMT_I, OPC_LOAD, 3'd0, 7'd0};
      lh:    r = '{FMT_I, OPC_LOAD, 3'd1, 7'd0};
      lw:    r = '{FMT_I, OPC_LOAD, 3'd2, 7'd0};
      lbu:   r = '{FMT_I, OPC_LOAD, 3'd4, 7'd0};
      lhu:   r = '{FMT_I, OPC_LOAD, 3'd5, 7'd0};
      sb:    r = '{FMT_S, OPC_STORE, 3'd0, 7'd0};
      sh:    r = '{FMT_S, OPC_STORE, 3'd1, 7'd0};
      sw:    r = '{FMT_S, OPC_STORE, 3'd2, 7'd0};
      addi:  r = '{FMT_I, OPC_OP_IMM, 3'd0, 7'd0};
      slti:  r = '{FMT_I, OPC_OP_IMM, 3'd2, 7'd0};
      sltiu: r = '{FMT_I, OPC_OP_IMM, 3'd3, 7'd0};
      xori:  r = '{FMT_I, OPC_OP_IMM, 3'd4, 7'd0};
      ori:   r = '{FMT_I, OPC_OP_IMM, 3'd6, 7'd0};
      andi:  r = '{FMT_I, OPC_OP_IMM, 3'd7, 7'd0};
      slli:  r = '{FMT_SHIFT, OPC_OP_IMM, 3'd1, 7'd0};
      srli:  r = '{FMT_SHIFT, OPC_OP_IMM, 3'd5, 7'd0};
      srai:  r = '{FMT_SHIFT, OPC_OP_IMM, 3'd5, F7_ALT};
      add:   r = '{FMT_R, OPC_OP, 3'd0, 7'd0};
      sub:   r = '{FMT_R, OPC_OP, 3'd0, F7_ALT};
      sll:   r = '{FMT_R, OPC_OP, 3'd1, 7'd0};
      slt:   r = '{FMT_R, OPC_OP, 3'd2, 7'd0};
      sltu:  r = '{FMT_R, OPC_OP, 3'd3, 7'd0};
      xor_:  r = '{FMT_R, OPC_OP, 3'd4, 7'd0};
      srl:   r = '{FMT_R, OPC_OP, 3'd5, 7'd0};
      sra:   r = '{FMT_R, OPC_OP, 3'd5, F7_ALT};
      or_:   r = '{FMT_R, OPC_OP, 3'd6, 7'd0};
      and_:  r = '{FMT_R, OPC_OP, 3'd7, 7'd0};
      default: r = '{FMT_NONE, 7'd0, 3'd0, 7'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Record-in / word-out stream bundle between a record producer and the encoder.
interface instruction_encoder_if import instruction_encoder_pkg::*; #(
  parameter int ADDRESS_WIDTH = 8
);
  logic                     in_valid;
  logic                     in_ready;
  operation_t               in_operation;
  logic [4:0]               in_rd;
  logic [4:0]               in_rs1;
  logic [4:0]               in_rs2;
  logic [31:0]              in_immediate;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDRESS_WIDTH-1:0] out_address;
  logic [31:0]              out_instruction;

  modport master (
    output in_valid, in_operation, in_rd, in_rs1, in_rs2, in_immediate, out_ready,
    input  in_ready, out_valid, out_address, out_instruction
  );
  modport slave (
    input  in_valid, in_operation, in_rd, in_rs1, in_rs2, in_immediate, out_ready,
    output in_ready, out_valid, out_address, out_instruction
  );
endinterface

// File: rtl/instruction_encoder_sync_fifo.sv
// Small synchronous FIFO with occupancy count; caller never pushes when full
// nor pops when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);
endmodule

// File: rtl/instruction_encoder.sv
// Packs decoded RV32I records into machine words and streams them, with a
// running word address, towards the instruction-memory write port.
module instruction_encoder import instruction_encoder_pkg::*; #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  instruction_encoder_if.slave     bus,
  input  logic                     load_address,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  input  logic                     clear_error,
  output logic                     error,
  output operation_t               error_operation
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  op_info_t                 info;
  logic [31:0]              imm, word;
  logic                     enc_err, accept, push, pop, fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic [ADDRESS_WIDTH-1:0] counter;

  // Encoding is combinational; the FIFO write is the registered encode stage,
  // which gives single-cycle latency from acceptance to the head.
  always_comb begin
    info    = op_info(bus.in_operation);
    imm     = bus.in_immediate;
    word    = '0;
    enc_err = 1'b0;
    case (info.fmt)
      FMT_R: word = {info.funct7, bus.in_rs2, bus.in_rs1, info.funct3, bus.in_rd, info.opcode};
      FMT_I: begin
        enc_err = ($signed(imm) < IMM_I_MIN) || ($signed(imm) > IMM_I_MAX);
        word    = {imm[11:0], bus.in_rs1, info.funct3, bus.in_rd, info.opcode};
      end
      FMT_SHIFT: begin
        enc_err = (imm[31:5] != '0);
        word    = {info.funct7, imm[4:0], bus.in_rs1, info.funct3, bus.in_rd, info.opcode};
      end
      FMT_S: begin
        enc_err = ($signed(imm) < IMM_I_MIN) || ($signed(imm) > IMM_I_MAX);
        word    = {imm[11:5], bus.in_rs2, bus.in_rs1, info.funct3, imm[4:0], info.opcode};
      end
      FMT_B: begin
        enc_err = ($signed(imm) < IMM_B_MIN) || ($signed(imm) > IMM_B_MAX) || imm[0];
        word    = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, info.funct3,
                   imm[4:1], imm[11], info.opcode};
      end
      FMT_U: begin
        enc_err = (imm[11:0] != '0);
        word    = {imm[31:12], bus.in_rd, info.opcode};
      end
      FMT_J: begin
        enc_err = ($signed(imm) < IMM_J_MIN) || ($signed(imm) > IMM_J_MAX) || imm[0];
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, info.opcode};
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign bus.in_ready = !reset && (fifo_count < CW'(FIFO_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && !enc_err;
  assign pop          = bus.out_valid && bus.out_ready;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (word),
    .pop       (pop),
    .pop_data  (bus.out_instruction),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.out_valid   = !fifo_empty;
  assign bus.out_address = counter;

  always_ff @(posedge clock) begin
    if (reset)             counter <= '0;
    else if (load_address) counter <= base_address;
    else if (pop)          counter <= counter + ADDRESS_WIDTH'(4);
  end

  // A new error wins over clear_error; the first failing op is kept until cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      error           <= 1'b0;
      error_operation <= invalid;
    end else if (accept && enc_err) begin
      error <= 1'b1;
      if (!error || clear_error) error_operation <= bus.in_operation;
    end else if (clear_error) begin
      error           <= 1'b0;
      error_operation <= invalid;
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: table of encodings plus hand-written
// backpressure, error, address-wrap and mid-stream reset sequences.
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;

  typedef struct {
    operation_t  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  localparam int NV = 12;

  logic       clock = 1'b0;
  logic       reset;
  logic       load_address;
  logic [7:0] base_address;
  logic       clear_error;
  logic       error;
  operation_t error_operation;

  int         tests  = 0;
  int         failed = 0;
  vec_t       vecs[NV];
  logic [7:0] exp_addr;

  instruction_encoder_if #(.ADDRESS_WIDTH(8)) bus ();

  instruction_encoder #(.ADDRESS_WIDTH(8), .FIFO_DEPTH(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus),
    .load_address    (load_address),
    .base_address    (base_address),
    .clear_error     (clear_error),
    .error           (error),
    .error_operation (error_operation)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_operation = v.op;
    bus.in_rd        = v.rd;
    bus.in_rs1       = v.rs1;
    bus.in_rs2       = v.rs2;
    bus.in_immediate = v.imm;
  endtask

  task automatic drive_raw(input operation_t op, input logic [31:0] imm);
    bus.in_operation = op;
    bus.in_rd        = 5'd1;
    bus.in_rs1       = 5'd2;
    bus.in_rs2       = 5'd3;
    bus.in_immediate = imm;
  endtask

  initial begin
    // Unused fields carry junk on purpose (sw rd, lui rs1/rs2, jal rs1/rs2).
    vecs[0]  = '{addi,  5'd1,  5'd0,  5'd0,  32'd5,        32'h00500093};
    vecs[1]  = '{lui,   5'd2,  5'd7,  5'd9,  32'h12345000, 32'h12345137};
    vecs[2]  = '{sub,   5'd3,  5'd1,  5'd2,  32'd0,        32'h402081B3};
    vecs[3]  = '{sw,    5'd31, 5'd1,  5'd2,  32'd8,        32'h0020A423};
    vecs[4]  = '{beq,   5'd0,  5'd0,  5'd0,  32'hFFFFFFF8, 32'hFE000CE3};
    vecs[5]  = '{srai,  5'd5,  5'd6,  5'd0,  32'd3,        32'h40335293};
    vecs[6]  = '{jal,   5'd1,  5'd4,  5'd5,  32'd8,        32'h008000EF};
    vecs[7]  = '{lw,    5'd5,  5'd2,  5'd0,  32'hFFFFFFFC, 32'hFFC12283};
    vecs[8]  = '{and_,  5'd10, 5'd11, 5'd12, 32'd0,        32'h00C5F533};
    vecs[9]  = '{bne,   5'd0,  5'd1,  5'd2,  32'd4094,     32'h7E209FE3};
    vecs[10] = '{addi,  5'd1,  5'd1,  5'd0,  32'hFFFFF800, 32'h80008093};
    vecs[11] = '{jal,   5'd0,  5'd0,  5'd0,  32'hFFF00000, 32'h8000006F};

    reset = 1'b1; load_address = 1'b0; base_address = '0; clear_error = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drive_raw(invalid, 32'd0);
    tick(); tick();
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_address", 32'(bus.out_address), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_error_op", 32'(error_operation), 32'(invalid));
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Table: each record accepted, seen one cycle later, then popped.
    exp_addr = '0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      bus.in_valid = 1'b1;
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_word", i), bus.out_instruction, vecs[i].word);
      chk($sformatf("vec%0d_addr", i), 32'(bus.out_address), 32'(exp_addr));
      tick();
      exp_addr = exp_addr + 8'd4;
    end
    chk("table_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: FIFO fills at two, head stays put, then drains in order.
    reset = 1'b1; tick(); reset = 1'b0;
    bus.out_ready = 1'b0;
    drive(vecs[0]); bus.in_valid = 1'b1; tick();
    drive(vecs[1]); tick();
    drive(vecs[2]);
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    tick(); tick();
    chk("bp_head_word", bus.out_instruction, vecs[0].word);
    chk("bp_head_addr", 32'(bus.out_address), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_drain1_word", bus.out_instruction, vecs[1].word);
    chk("bp_drain1_addr", 32'(bus.out_address), 32'd4);
    chk("bp_in_ready_again", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_drain2_word", bus.out_instruction, vecs[2].word);
    chk("bp_drain2_addr", 32'(bus.out_address), 32'd8);
    tick();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);
    chk("bp_final_addr", 32'(bus.out_address), 32'd12);

    // Errors: range and alignment violations produce no word.
    drive_raw(addi, 32'd4096); bus.in_valid = 1'b1; tick();
    chk("err_addi_set", 32'(error), 32'd1);
    chk("err_addi_op", 32'(error_operation), 32'(addi));
    drive_raw(beq, 32'd3); tick();
    bus.in_valid = 1'b0;
    chk("err_first_op_kept", 32'(error_operation), 32'(addi));
    chk("err_no_word", 32'(bus.out_valid), 32'd0);
    chk("err_addr_unchanged", 32'(bus.out_address), 32'd12);
    clear_error = 1'b1; tick(); clear_error = 1'b0;
    chk("err_cleared", 32'(error), 32'd0);
    chk("err_op_cleared", 32'(error_operation), 32'(invalid));
    drive_raw(fence, 32'd0); bus.in_valid = 1'b1; tick(); bus.in_valid = 1'b0;
    chk("err_fence", 32'(error), 32'd1);
    chk("err_fence_op", 32'(error_operation), 32'(fence));
    clear_error = 1'b1; drive_raw(srli, 32'd32); bus.in_valid = 1'b1; tick();
    bus.in_valid = 1'b0; clear_error = 1'b0;
    chk("err_clear_vs_new", 32'(error), 32'd1);
    chk("err_shift_no_word", 32'(bus.out_valid), 32'd0);
    drive_raw(lui, 32'h00000123); bus.in_valid = 1'b1; tick(); bus.in_valid = 1'b0;
    chk("err_lui_no_word", 32'(bus.out_valid), 32'd0);
    clear_error = 1'b1; tick(); clear_error = 1'b0;
    chk("err_cleared2", 32'(error), 32'd0);

    // Address load and wrap, then load taking priority over a pop.
    load_address = 1'b1; base_address = 8'hFC; tick(); load_address = 1'b0;
    chk("load_addr", 32'(bus.out_address), 32'hFC);
    drive(vecs[0]); bus.in_valid = 1'b1; tick();
    chk("wrap_word0", bus.out_instruction, vecs[0].word);
    chk("wrap_addr0", 32'(bus.out_address), 32'hFC);
    drive(vecs[1]); tick();
    bus.in_valid = 1'b0;
    chk("wrap_word1", bus.out_instruction, vecs[1].word);
    chk("wrap_addr1", 32'(bus.out_address), 32'h00);
    load_address = 1'b1; base_address = 8'h40; tick(); load_address = 1'b0;
    chk("load_over_pop_addr", 32'(bus.out_address), 32'h40);
    chk("load_over_pop_empty", 32'(bus.out_valid), 32'd0);

    // Reset while full flushes everything.
    bus.out_ready = 1'b0;
    drive(vecs[3]); bus.in_valid = 1'b1; tick();
    drive(vecs[4]); tick();
    bus.in_valid = 1'b0;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1; tick();
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_addr", 32'(bus.out_address), 32'd0);
    reset = 1'b0; #1;
    chk("midrst_ready_after", 32'(bus.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
